// File: rtl/xvec2_vscale_vecfile_param.sv
// Grouped vector register file: VEC_SIZE lanes per group, per-lane masked writes,
// optional write-to-read forwarding, per-group pending bits and a zero-fill init sweep.
module xvec2_vscale_vecfile_param #(
  parameter int XPR_LEN  = 32,
  parameter int VEC_SIZE = 4,
  parameter int NUM_XPR  = 32,
  parameter int BYPASS   = 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [$clog2(NUM_XPR)-1:0]    ra1,
  input  logic [$clog2(NUM_XPR)-1:0]    ra2,
  output logic [VEC_SIZE*XPR_LEN-1:0]   rd1,
  output logic [VEC_SIZE*XPR_LEN-1:0]   rd2,
  input  logic                          wen,
  input  logic [$clog2(NUM_XPR)-1:0]    wa,
  input  logic [VEC_SIZE-1:0]           wmask,
  input  logic [VEC_SIZE*XPR_LEN-1:0]   wd,
  input  logic                          mark_pend,
  input  logic [$clog2(NUM_XPR)-1:0]    mark_addr,
  output logic                          pend1,
  output logic                          pend2,
  output logic                          ready
);

  localparam int AW      = $clog2(NUM_XPR);
  localparam int LW      = $clog2(VEC_SIZE);
  localparam int GW      = AW - LW;
  localparam int NGROUPS = NUM_XPR / VEC_SIZE;
  localparam int DW      = VEC_SIZE * XPR_LEN;
  localparam logic [AW-1:0] LO_MASK = AW'(VEC_SIZE - 1);

  typedef logic [GW-1:0] grp_t;
  typedef enum logic {S_INIT, S_READY} state_t;

  function automatic grp_t grp(input logic [AW-1:0] a);
    return a[AW-1:LW];
  endfunction

  state_t               state_q, state_d;
  grp_t                 cnt_q, cnt_d;
  logic [NGROUPS-1:0]   pend_q, pend_d;

  grp_t                 ra1_g, ra2_g, wa_g, mk_g;
  logic                 wr_en;
  grp_t                 wr_grp;
  logic [VEC_SIZE-1:0]  wr_lanes;
  logic [DW-1:0]        wr_data;
  logic                 byp_en;
  logic                 unused_addr_bits;

  assign ra1_g = grp(ra1);
  assign ra2_g = grp(ra2);
  assign wa_g  = grp(wa);
  assign mk_g  = grp(mark_addr);
  assign unused_addr_bits = ^{ra1 & LO_MASK, ra2 & LO_MASK, wa & LO_MASK, mark_addr & LO_MASK};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_INIT;
      cnt_q   <= grp_t'(1);
      pend_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == S_INIT) begin
      if (cnt_q == grp_t'(NGROUPS - 1)) state_d = S_READY;
      else                              cnt_d   = cnt_q + grp_t'(1);
    end
  end

  // The init sweep and user writes share one write port; init owns it until READY.
  always_comb begin
    ready    = (state_q == S_READY);
    wr_en    = 1'b0;
    wr_grp   = wa_g;
    wr_lanes = wmask;
    wr_data  = wd;
    if (state_q == S_INIT) begin
      wr_en    = 1'b1;
      wr_grp   = cnt_q;
      wr_lanes = '1;
      wr_data  = '0;
    end else if (wen && wa_g != '0) begin
      wr_en    = 1'b1;
    end
  end

  // Clear first so a coincident mark on the same group wins.
  always_comb begin
    pend_d = pend_q;
    if (ready) begin
      if (wen && wa_g != '0)       pend_d[wa_g] = 1'b0;
      if (mark_pend && mk_g != '0) pend_d[mk_g] = 1'b1;
    end
  end

  assign pend1  = ready & pend_q[ra1_g];
  assign pend2  = ready & pend_q[ra2_g];
  assign byp_en = (BYPASS != 0) && ready && wen;

  for (genvar i = 0; i < VEC_SIZE; i++) begin : g_lane
    logic [XPR_LEN-1:0] mem_q [NGROUPS];
    logic [XPR_LEN-1:0] r1, r2;

    always_ff @(posedge clk) begin
      if (wr_en && wr_lanes[i]) mem_q[wr_grp] <= wr_data[i*XPR_LEN +: XPR_LEN];
    end

    always_comb begin
      r1 = '0;
      r2 = '0;
      if (ready && ra1_g != '0)
        r1 = (byp_en && ra1_g == wa_g && wmask[i]) ? wd[i*XPR_LEN +: XPR_LEN] : mem_q[ra1_g];
      if (ready && ra2_g != '0)
        r2 = (byp_en && ra2_g == wa_g && wmask[i]) ? wd[i*XPR_LEN +: XPR_LEN] : mem_q[ra2_g];
    end

    assign rd1[i*XPR_LEN +: XPR_LEN] = r1;
    assign rd2[i*XPR_LEN +: XPR_LEN] = r2;
  end

endmodule

// File: tb/tb_xvec2_vscale_vecfile_param.sv
// Directed bench for xvec2_vscale_vecfile_param: default config, a no-bypass twin,
// and VEC_SIZE 1/2/8 variants sharing clock and reset.
module tb_xvec2_vscale_vecfile_param;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic [4:0]   ra1, ra2, wa, mark_addr;
  logic         wen, mark_pend;
  logic [3:0]   wmask;
  logic [127:0] wd, rd1, rd2, rd1_nb, rd2_nb;
  logic         pend1, pend2, ready, pend1_nb, pend2_nb, ready_nb;

  logic [4:0]   s1_ra, s1_wa, s2_ra, s2_wa, s8_ra, s8_wa;
  logic         s1_wen, s2_wen, s8_wen;
  logic [0:0]   s1_wmask;
  logic [1:0]   s2_wmask;
  logic [7:0]   s8_wmask;
  logic [31:0]  s1_wd, s1_rd, s1_rd2;
  logic [63:0]  s2_wd, s2_rd, s2_rd2;
  logic [255:0] s8_wd, s8_rd, s8_rd2;
  logic         s1_ready, s2_ready, s8_ready;
  logic [1:0]   s1_p, s2_p, s8_p;

  xvec2_vscale_vecfile_param #(.XPR_LEN(32), .VEC_SIZE(4), .NUM_XPR(32), .BYPASS(1)) u_dut (
    .clk(clk), .reset(reset), .ra1(ra1), .ra2(ra2), .rd1(rd1), .rd2(rd2),
    .wen(wen), .wa(wa), .wmask(wmask), .wd(wd), .mark_pend(mark_pend), .mark_addr(mark_addr),
    .pend1(pend1), .pend2(pend2), .ready(ready));

  xvec2_vscale_vecfile_param #(.XPR_LEN(32), .VEC_SIZE(4), .NUM_XPR(32), .BYPASS(0)) u_nb (
    .clk(clk), .reset(reset), .ra1(ra1), .ra2(ra2), .rd1(rd1_nb), .rd2(rd2_nb),
    .wen(wen), .wa(wa), .wmask(wmask), .wd(wd), .mark_pend(mark_pend), .mark_addr(mark_addr),
    .pend1(pend1_nb), .pend2(pend2_nb), .ready(ready_nb));

  xvec2_vscale_vecfile_param #(.XPR_LEN(32), .VEC_SIZE(1), .NUM_XPR(32), .BYPASS(1)) u_s1 (
    .clk(clk), .reset(reset), .ra1(s1_ra), .ra2(s1_ra), .rd1(s1_rd), .rd2(s1_rd2),
    .wen(s1_wen), .wa(s1_wa), .wmask(s1_wmask), .wd(s1_wd), .mark_pend(1'b0), .mark_addr(5'd0),
    .pend1(s1_p[0]), .pend2(s1_p[1]), .ready(s1_ready));

  xvec2_vscale_vecfile_param #(.XPR_LEN(32), .VEC_SIZE(2), .NUM_XPR(32), .BYPASS(1)) u_s2 (
    .clk(clk), .reset(reset), .ra1(s2_ra), .ra2(s2_ra), .rd1(s2_rd), .rd2(s2_rd2),
    .wen(s2_wen), .wa(s2_wa), .wmask(s2_wmask), .wd(s2_wd), .mark_pend(1'b0), .mark_addr(5'd0),
    .pend1(s2_p[0]), .pend2(s2_p[1]), .ready(s2_ready));

  xvec2_vscale_vecfile_param #(.XPR_LEN(32), .VEC_SIZE(8), .NUM_XPR(32), .BYPASS(1)) u_s8 (
    .clk(clk), .reset(reset), .ra1(s8_ra), .ra2(s8_ra), .rd1(s8_rd), .rd2(s8_rd2),
    .wen(s8_wen), .wa(s8_wa), .wmask(s8_wmask), .wd(s8_wd), .mark_pend(1'b0), .mark_addr(5'd0),
    .pend1(s8_p[0]), .pend2(s8_p[1]), .ready(s8_ready));

  int n_asserts = 0;
  int n_fail    = 0;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  int edges, e_dut, e_nb, e_s1, e_s2, e_s8;
  logic [255:0] exp8;

  initial begin
    ra1 = 5'd4; ra2 = 5'd0; wa = '0; mark_addr = '0; wen = 0; mark_pend = 0; wmask = '0; wd = '0;
    s1_ra = '0; s1_wa = '0; s1_wen = 0; s1_wmask = '0; s1_wd = '0;
    s2_ra = '0; s2_wa = '0; s2_wen = 0; s2_wmask = '0; s2_wd = '0;
    s8_ra = '0; s8_wa = '0; s8_wen = 0; s8_wmask = '0; s8_wd = '0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ready", ready, 0);
    check("rst_rd1", rd1, 0);
    check("rst_pend1", pend1, 0);

    // Release reset and measure init length of every configuration.
    reset = 0;
    edges = 0; e_dut = 0; e_nb = 0; e_s1 = 0; e_s2 = 0; e_s8 = 0;
    while (edges < 40 && !(ready && ready_nb && s1_ready && s2_ready && s8_ready)) begin
      @(posedge clk); #1;
      edges++;
      if (ready    && e_dut == 0) e_dut = edges;
      if (ready_nb && e_nb  == 0) e_nb  = edges;
      if (s1_ready && e_s1  == 0) e_s1  = edges;
      if (s2_ready && e_s2  == 0) e_s2  = edges;
      if (s8_ready && e_s8  == 0) e_s8  = edges;
      if (edges == 3) begin
        check("init_ready_low", ready, 0);
        check("init_rd1_zero", rd1, 0);
      end
    end
    check("init_len_v4", e_dut, 7);
    check("init_len_v4_nb", e_nb, 7);
    check("init_len_v1", e_s1, 31);
    check("init_len_v2", e_s2, 15);
    check("init_len_v8", e_s8, 3);

    @(negedge clk);
    for (int g = 0; g < 8; g++) begin
      ra1 = 5'(g * 4); #1;
      check($sformatf("zero_grp%0d", g), rd1, 0);
    end

    // Masked write with same-cycle forwarding.
    wen = 1; wa = 5'd8; wmask = 4'b0101; wd = {32'hD, 32'hC, 32'hB, 32'hA}; ra1 = 5'd8; ra2 = 5'd11;
    #1;
    check("byp_rd1", rd1, {32'h0, 32'hC, 32'h0, 32'hA});
    check("byp_rd2", rd2, {32'h0, 32'hC, 32'h0, 32'hA});
    check("nobyp_rd1", rd1_nb, 0);
    @(posedge clk); #1; wen = 0; #1;
    check("wr1_stored", rd1, {32'h0, 32'hC, 32'h0, 32'hA});
    check("wr1_stored_nb", rd1_nb, {32'h0, 32'hC, 32'h0, 32'hA});

    @(negedge clk);
    wen = 1; wa = 5'd9; wmask = 4'b1010; wd = {32'h4, 32'h3, 32'h2, 32'h1};
    #1;
    check("byp2_rd1", rd1, {32'h4, 32'hC, 32'h2, 32'hA});
    check("nobyp2_rd1", rd1_nb, {32'h0, 32'hC, 32'h0, 32'hA});
    @(posedge clk); #1; wen = 0; #1;
    check("wr2_stored", rd1, {32'h4, 32'hC, 32'h2, 32'hA});

    // Group 0 ignores writes and marks.
    @(negedge clk);
    wen = 1; wa = 5'd2; wmask = 4'hF; wd = '1; ra1 = 5'd0; mark_pend = 1; mark_addr = 5'd1;
    #1;
    check("g0_byp", rd1, 0);
    @(posedge clk); #1; wen = 0; mark_pend = 0; #1;
    check("g0_stored", rd1, 0);
    check("g0_pend", pend1, 0);

    // Pending bits.
    @(negedge clk);
    mark_pend = 1; mark_addr = 5'd12; ra1 = 5'd13; ra2 = 5'd8;
    #1;
    check("pend_no_fwd", pend1, 0);
    @(posedge clk); #1; mark_pend = 0; #1;
    check("pend_set", pend1, 1);
    check("pend_other", pend2, 0);

    @(negedge clk);
    wen = 1; wa = 5'd12; wmask = '0; mark_pend = 1; mark_addr = 5'd12;
    @(posedge clk); #1; wen = 0; mark_pend = 0; #1;
    check("pend_set_wins", pend1, 1);

    @(negedge clk);
    wen = 1; wa = 5'd14; wmask = '0; ra2 = 5'd12;
    #1;
    check("pend_clr_no_fwd", pend1, 1);
    @(posedge clk); #1; wen = 0; #1;
    check("pend_clr", pend1, 0);
    check("mask0_hold", rd2, 0);

    // Lane-count sweep: masked writes with forwarding.
    @(negedge clk);
    s8_wen = 1; s8_wa = 5'd8; s8_wmask = 8'h81; s8_ra = 5'd15;
    for (int i = 0; i < 8; i++) s8_wd[i*32 +: 32] = 32'(i + 1);
    s2_wen = 1; s2_wa = 5'd6; s2_wmask = 2'b10; s2_wd = {32'hB2, 32'hA2}; s2_ra = 5'd7;
    s1_wen = 1; s1_wa = 5'd5; s1_wmask = 1'b1; s1_wd = 32'h55; s1_ra = 5'd5;
    exp8 = '0; exp8[31:0] = 32'h1; exp8[255:224] = 32'h8;
    #1;
    check("v8_byp", s8_rd, exp8);
    check("v2_byp", s2_rd, {32'hB2, 32'h0});
    check("v1_byp", s1_rd, 32'h55);
    @(posedge clk); #1; s8_wen = 0; s2_wen = 0; s1_wen = 0; #1;
    check("v8_stored", s8_rd, exp8);
    check("v2_stored", s2_rd, {32'hB2, 32'h0});
    check("v1_stored", s1_rd, 32'h55);

    @(negedge clk);
    s1_wen = 1; s1_wmask = 1'b0; s1_wd = 32'hFF;
    #1;
    check("v1_mask0_byp", s1_rd, 32'h55);
    @(posedge clk); #1; s1_wen = 0; #1;
    check("v1_mask0_hold", s1_rd, 32'h55);

    // Reset during operation, then again mid-init.
    @(negedge clk);
    mark_pend = 1; mark_addr = 5'd20; ra2 = 5'd20; ra1 = 5'd8;
    @(posedge clk); #1; mark_pend = 0; #1;
    check("pend5_set", pend2, 1);
    @(negedge clk);
    reset = 1; #1;
    check("arst_ready", ready, 0);
    check("arst_pend", pend2, 0);
    check("arst_rd1", rd1, 0);
    @(negedge clk);
    reset = 0; wen = 1; wa = 5'd8; wmask = 4'hF; wd = '1;
    repeat (3) @(posedge clk);
    #1;
    check("mid_init_ready", ready, 0);
    check("mid_init_rd1", rd1, 0);
    @(negedge clk); reset = 1;
    @(negedge clk); reset = 0;
    edges = 0;
    while (edges < 20 && !ready) begin
      @(posedge clk); #1;
      edges++;
    end
    wen = 0;
    check("reinit_len", edges, 7);
    #1;
    check("reinit_rd1", rd1, 0);
    check("reinit_pend", pend2, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
